// File: rtl/crc_stream_pkg.sv
// Shared types and helpers for the streaming CRC appender.
// Holds the FSM state encoding, the widest supported CRC and a bit-reflect helper.
package crc_stream_pkg;

    localparam int CRC_MAX_W = 32;

    typedef enum logic {
        ST_PASS   = 1'b0,
        ST_APPEND = 1'b1
    } crc_state_e;

    // Reverse the low w bits of v; bits at and above w come back as zero.
    function automatic logic [CRC_MAX_W-1:0] reflect(input logic [CRC_MAX_W-1:0] v, input int w);
        logic [CRC_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < CRC_MAX_W; i++) begin
            if (i < w) r[i] = v[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_byte_update.sv
// Next CRC register value after absorbing one byte, MSB-first shift register form.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// Flow: caller decides when the result is captured.
module crc_byte_update
    import crc_stream_pkg::*;
#(
    parameter int unsigned CRC_W = 32,
    parameter logic [31:0] POLY  = 32'h04C11DB7,
    parameter bit          REFIN = 1'b1
) (
    input  logic [CRC_W-1:0] i_crc,
    input  logic [7:0]       i_data,
    output logic [CRC_W-1:0] o_crc
);

    logic [7:0]       w_din;
    logic [CRC_W-1:0] w_c;

    always_comb begin
        w_din = REFIN ? 8'(reflect(32'(i_data), 8)) : i_data;
        w_c   = i_crc ^ (CRC_W'(w_din) << (CRC_W - 8));
        for (int b = 0; b < 8; b++) begin
            if (w_c[CRC_W-1]) w_c = (w_c << 1) ^ POLY[CRC_W-1:0];
            else              w_c = w_c << 1;
        end
        o_crc = w_c;
    end

endmodule

// File: rtl/crc_stream_append.sv
// Byte-stream CRC appender: forwards payload, then emits CRC_W/8 CRC bytes; optional CRC_STREAM_FRAME_CNT_EN adds frame_cnt_o.
// Latency: one cycle input to output through a single output register.
// Backpressure: input stalls while the output register is held or CRC bytes are being emitted.
module crc_stream_append
    import crc_stream_pkg::*;
#(
    parameter int unsigned CRC_W  = 32,
    parameter logic [31:0] POLY   = 32'h04C11DB7,
    parameter logic [31:0] INIT   = 32'hFFFFFFFF,
    parameter bit          REFIN  = 1'b1,
    parameter bit          REFOUT = 1'b1,
    parameter logic [31:0] XOROUT = 32'hFFFFFFFF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [7:0]       s_data_i,
    input  logic             s_valid_i,
    input  logic             s_last_i,
    output logic             s_ready_o,
    output logic [7:0]       m_data_o,
    output logic             m_valid_o,
    output logic             m_last_o,
    input  logic             m_ready_i,
    output logic [CRC_W-1:0] crc_o,
    output logic             crc_valid_o
`ifdef CRC_STREAM_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt_o
`endif
);

    localparam int NB = CRC_W / 8;

    crc_state_e       r_state, w_state_nxt;
    logic [1:0]       r_cnt, w_cnt_nxt;
    logic [CRC_W-1:0] r_crc, r_crc_o;
    logic [CRC_W-1:0] w_crc_upd, w_crc_fin;
    logic             r_crc_vld;
    logic             r_rdy_en;
    logic [7:0]       r_m_data;
    logic             r_m_valid, r_m_last;
    logic             w_out_free, w_final_hs, w_accept, w_load_crc, w_s_ready;
    logic [1:0]       w_idx;
    logic [7:0]       w_crc_byte;

    crc_byte_update #(
        .CRC_W (CRC_W),
        .POLY  (POLY),
        .REFIN (REFIN)
    ) u_upd (
        .i_crc  (r_crc),
        .i_data (s_data_i),
        .o_crc  (w_crc_upd)
    );

    assign w_crc_fin = (REFOUT ? CRC_W'(reflect(32'(w_crc_upd), int'(CRC_W))) : w_crc_upd)
                       ^ XOROUT[CRC_W-1:0];

    assign w_out_free = !r_m_valid || m_ready_i;
    // The final CRC byte leaving frees the output register for the next frame's first byte.
    assign w_final_hs = (r_state == ST_APPEND) && r_m_valid && r_m_last && m_ready_i;
    assign w_s_ready  = r_rdy_en && (((r_state == ST_PASS) && w_out_free) || w_final_hs);
    assign w_accept   = s_valid_i && w_s_ready;
    assign w_load_crc = (r_state == ST_APPEND) && !(r_m_valid && r_m_last) && w_out_free;

    assign w_idx      = REFOUT ? r_cnt : (2'(NB - 1) - r_cnt);
    assign w_crc_byte = 8'(r_crc_o >> {w_idx, 3'b000});

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_PASS: begin
                if (w_accept && s_last_i) w_state_nxt = ST_APPEND;
            end
            ST_APPEND: begin
                if (w_load_crc) w_cnt_nxt = r_cnt + 2'd1;
                if (w_final_hs) begin
                    w_cnt_nxt   = 2'd0;
                    w_state_nxt = (w_accept && s_last_i) ? ST_APPEND : ST_PASS;
                end
            end
            default: w_state_nxt = ST_PASS;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_PASS;
            r_cnt     <= 2'd0;
            r_rdy_en  <= 1'b0;
            r_crc     <= INIT[CRC_W-1:0];
            r_crc_o   <= '0;
            r_crc_vld <= 1'b0;
            r_m_data  <= 8'd0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rdy_en  <= 1'b1;
            r_crc_vld <= w_accept && s_last_i;
            if (w_accept) begin
                r_crc <= s_last_i ? INIT[CRC_W-1:0] : w_crc_upd;
                if (s_last_i) r_crc_o <= w_crc_fin;
            end
            if (w_accept) begin
                r_m_data  <= s_data_i;
                r_m_last  <= 1'b0;
                r_m_valid <= 1'b1;
            end else if (w_load_crc) begin
                r_m_data  <= w_crc_byte;
                r_m_last  <= (r_cnt == 2'(NB - 1));
                r_m_valid <= 1'b1;
            end else if (m_ready_i) begin
                r_m_valid <= 1'b0;
            end
        end
    end

`ifdef CRC_STREAM_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)         r_frame_cnt <= 16'd0;
        else if (w_final_hs) r_frame_cnt <= r_frame_cnt + 16'd1;
    end

    assign frame_cnt_o = r_frame_cnt;
`endif

    assign s_ready_o   = w_s_ready;
    assign m_data_o    = r_m_data;
    assign m_valid_o   = r_m_valid;
    assign m_last_o    = r_m_last;
    assign crc_o       = r_crc_o;
    assign crc_valid_o = r_crc_vld;

endmodule
